// File: rtl/vga_image_scan_if.sv
// Signal bundle between the VGA scanner, its image ROM and the VGA connector pins.
// The ROM link has no valid/ready: colour_data is taken ROM_LATENCY clocks after image_addr, with no backpressure.
interface vga_image_scan_if #(
  parameter int width    = 24,
  parameter int addrSize = 13
);
  logic [addrSize-1:0] image_addr;
  logic [width-1:0]    colour_data;
  logic [7:0]          vga_r;
  logic [7:0]          vga_g;
  logic [7:0]          vga_b;
  logic                vga_hs;
  logic                vga_vs;
  logic                vga_blank_n;
  logic                frame_start;

  modport master (
    output image_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
    input  colour_data
  );

  modport slave (
    input  image_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
    output colour_data
  );
endinterface

// File: rtl/vga_image_scan.sv
// 640x480@60 VGA scanner: raster counters, incremental ROM addressing for a picture window,
// and a sync/blank pipe that matches the ROM latency so pins stay aligned.
module vga_image_scan #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int IMG_W       = 80,
  parameter int IMG_H       = 80,
  parameter int IMG_X       = 0,
  parameter int IMG_Y       = 0,
  parameter int width       = 24,
  parameter int addrSize    = 13,
  parameter int ROM_LATENCY = 1,
  parameter logic [width-1:0] BG_COLOUR = '0
) (
  input  logic             clk_25M,
  input  logic             reset,
  vga_image_scan_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PIPE    = 1 + ROM_LATENCY;

  logic [HW-1:0]       r_h_cnt;
  logic [VW-1:0]       r_v_cnt;
  logic [addrSize-1:0] r_image_addr;
  logic [addrSize-1:0] r_next_addr;
  logic [PIPE-1:0]     r_vis_p, r_win_p, r_hs_p, r_vs_p, r_frame_p;
  logic [width-1:0]    r_rgb;
  logic                r_hs, r_vs, r_blank_n, r_frame_start;

  logic          w_h_wrap, w_v_wrap, w_visible, w_in_win, w_hs_n, w_vs_n, w_frame;
  logic [HW-1:0] w_h_rel;
  logic [VW-1:0] w_v_rel;

  assign w_h_wrap  = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_wrap  = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_visible = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_n    = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs_n    = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign w_frame   = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Positions left of / above the window wrap to large unsigned values, so one compare per axis suffices.
  assign w_h_rel   = r_h_cnt - HW'(IMG_X);
  assign w_v_rel   = r_v_cnt - VW'(IMG_Y);
  assign w_in_win  = w_visible && (w_h_rel < HW'(IMG_W)) && (w_v_rel < VW'(IMG_H));

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // r_next_addr counts windowed pixels issued this frame; image_addr holds between them.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      r_image_addr <= '0;
      r_next_addr  <= '0;
    end else if (w_frame) begin
      r_image_addr <= '0;
      r_next_addr  <= {{(addrSize-1){1'b0}}, w_in_win};
    end else if (w_in_win) begin
      r_image_addr <= r_next_addr;
      r_next_addr  <= r_next_addr + 1'b1;
    end
  end

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      r_vis_p   <= '0;
      r_win_p   <= '0;
      r_hs_p    <= '1;
      r_vs_p    <= '1;
      r_frame_p <= '0;
    end else begin
      r_vis_p   <= {r_vis_p[PIPE-2:0],   w_visible};
      r_win_p   <= {r_win_p[PIPE-2:0],   w_in_win};
      r_hs_p    <= {r_hs_p[PIPE-2:0],    w_hs_n};
      r_vs_p    <= {r_vs_p[PIPE-2:0],    w_vs_n};
      r_frame_p <= {r_frame_p[PIPE-2:0], w_frame};
    end
  end

  // colour_data is only selected when the delayed window flag is set, keeping ROM X off the pins.
  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs          <= r_hs_p[PIPE-1];
      r_vs          <= r_vs_p[PIPE-1];
      r_blank_n     <= r_vis_p[PIPE-1];
      r_frame_start <= r_frame_p[PIPE-1];
      if (!r_vis_p[PIPE-1])
        r_rgb <= '0;
      else if (r_win_p[PIPE-1])
        r_rgb <= bus.colour_data;
      else
        r_rgb <= BG_COLOUR;
    end
  end

  assign bus.image_addr  = r_image_addr;
  assign bus.vga_r       = r_rgb[width-1 -: 8];
  assign bus.vga_g       = r_rgb[width-9 -: 8];
  assign bus.vga_b       = r_rgb[7:0];
  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.vga_blank_n = r_blank_n;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_image_scan.sv
// Bench for vga_image_scan: three instances (default, offset window with 2-clock ROM, tiny raster)
// checked every cycle against an arithmetic screen model driven by clocks since reset release.
module tb_vga_image_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;
  int   k_a, k_b, k_c;
  logic [23:0] rom_tab [0:8191];

  localparam logic [27:0] PINS_RST = {24'h0, 4'b1100};

  vga_image_scan_if #(.width(24), .addrSize(13)) if_a ();
  vga_image_scan_if #(.width(24), .addrSize(13)) if_b ();
  vga_image_scan_if #(.width(24), .addrSize(4))  if_c ();

  vga_image_scan u_a (.clk_25M(clk), .reset(rst_a), .bus(if_a));

  vga_image_scan #(
    .IMG_X(100), .IMG_Y(50), .ROM_LATENCY(2), .BG_COLOUR(24'hA5A5A5)
  ) u_b (.clk_25M(clk), .reset(rst_b), .bus(if_b));

  vga_image_scan #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(4), .IMG_H(3), .IMG_X(5), .IMG_Y(4),
    .addrSize(4), .ROM_LATENCY(3), .BG_COLOUR(24'h123456)
  ) u_c (.clk_25M(clk), .reset(rst_c), .bus(if_c));

  // ROM models: A returns its address, B and C read a random table
  logic [23:0] rom_a_q;
  logic [23:0] rom_b_q [2];
  logic [23:0] rom_c_q [3];
  always @(posedge clk) begin
    rom_a_q    <= 24'(if_a.image_addr);
    rom_b_q[0] <= rom_tab[if_b.image_addr];
    rom_b_q[1] <= rom_b_q[0];
    rom_c_q[0] <= rom_tab[13'(if_c.image_addr)];
    rom_c_q[1] <= rom_c_q[0];
    rom_c_q[2] <= rom_c_q[1];
  end
  assign if_a.colour_data = rom_a_q;
  assign if_b.colour_data = rom_b_q[1];
  assign if_c.colour_data = rom_c_q[2];

  // clocks since reset release, per instance
  always @(posedge clk) begin
    k_a <= rst_a ? k_a + 1 : 0;
    k_b <= rst_b ? k_b + 1 : 0;
    k_c <= rst_c ? k_c + 1 : 0;
  end

  logic [27:0] pins_a, pins_b, pins_c;
  assign pins_a = {if_a.vga_r, if_a.vga_g, if_a.vga_b, if_a.vga_hs, if_a.vga_vs, if_a.vga_blank_n, if_a.frame_start};
  assign pins_b = {if_b.vga_r, if_b.vga_g, if_b.vga_b, if_b.vga_hs, if_b.vga_vs, if_b.vga_blank_n, if_b.frame_start};
  assign pins_c = {if_c.vga_r, if_c.vga_g, if_c.vga_b, if_c.vga_hs, if_c.vga_vs, if_c.vga_blank_n, if_c.frame_start};

  // ---------------- reference model ----------------
  typedef struct {
    int hact, hfp, hsy, ht, vact, vfp, vsy, vt, iw, ih, ix, iy, lat;
    logic [23:0] bg;
  } cfg_t;

  function automatic cfg_t cfg_of(int d);
    cfg_t c;
    c = '{hact:640, hfp:16, hsy:96, ht:800, vact:480, vfp:10, vsy:2, vt:525,
          iw:80, ih:80, ix:0, iy:0, lat:1, bg:24'h000000};
    if (d == 1) begin
      c.ix = 100; c.iy = 50; c.lat = 2; c.bg = 24'hA5A5A5;
    end else if (d == 2) begin
      c = '{hact:16, hfp:2, hsy:4, ht:24, vact:12, vfp:2, vsy:2, vt:19,
            iw:4, ih:3, ix:5, iy:4, lat:3, bg:24'h123456};
    end
    return c;
  endfunction

  // Pins expected k clocks after release: pixel index p = k - (2 + ROM latency).
  function automatic logic [27:0] exp_pins(int d, int k);
    cfg_t c;
    int p, h, v, a;
    logic vis, win, hs, vs, fs;
    logic [23:0] rgb;
    c = cfg_of(d);
    p = k - 2 - c.lat;
    if (p < 0) return PINS_RST;
    h   = p % c.ht;
    v   = (p / c.ht) % c.vt;
    vis = (h < c.hact) && (v < c.vact);
    win = vis && (h >= c.ix) && (h < c.ix + c.iw) && (v >= c.iy) && (v < c.iy + c.ih);
    hs  = !((h >= c.hact + c.hfp) && (h < c.hact + c.hfp + c.hsy));
    vs  = !((v >= c.vact + c.vfp) && (v < c.vact + c.vfp + c.vsy));
    fs  = (h == 0) && (v == 0);
    a   = (v - c.iy) * c.iw + (h - c.ix);
    if (!vis)      rgb = 24'h0;
    else if (win)  rgb = (d == 0) ? 24'(a) : rom_tab[a];
    else           rgb = c.bg;
    return {rgb, hs, vs, vis, fs};
  endfunction

  // image_addr k clocks after release reflects pixel k-1: last windowed pixel issued so far this frame.
  function automatic int exp_addr(int d, int k);
    cfg_t c;
    int q, h, v, rows, cnt;
    logic win;
    c = cfg_of(d);
    q = k - 1;
    if (q < 0) return 0;
    h    = q % c.ht;
    v    = (q / c.ht) % c.vt;
    win  = (h >= c.ix) && (h < c.ix + c.iw) && (v >= c.iy) && (v < c.iy + c.ih);
    rows = (v < c.iy) ? 0 : ((v >= c.iy + c.ih) ? c.ih : v - c.iy);
    cnt  = rows * c.iw;
    if ((v >= c.iy) && (v < c.iy + c.ih))
      cnt += (h < c.ix) ? 0 : ((h >= c.ix + c.iw) ? c.iw : h - c.ix);
    return win ? cnt : ((cnt == 0) ? 0 : cnt - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (pins_a !== PINS_RST || if_a.image_addr !== 13'd0) begin
        errors++; $display("FAIL reset_a: pins %h addr %0d, want %h addr 0", pins_a, if_a.image_addr, PINS_RST);
      end
      if (pins_b !== PINS_RST || if_b.image_addr !== 13'd0) begin
        errors++; $display("FAIL reset_b: pins %h addr %0d, want %h addr 0", pins_b, if_b.image_addr, PINS_RST);
      end
      if (pins_c !== PINS_RST || if_c.image_addr !== 4'd0) begin
        errors++; $display("FAIL reset_c: pins %h addr %0d, want %h addr 0", pins_c, if_c.image_addr, PINS_RST);
      end
    end
  endtask

  task automatic test_startup();
    for (int i = 1; i <= 6; i++) begin
      step();
      checks += 3;
      if (if_a.frame_start !== (i == 3)) begin
        errors++; $display("FAIL startup_fs: edge %0d frame_start %b want %b", i, if_a.frame_start, (i == 3));
      end
      if (if_a.vga_blank_n !== (i >= 3)) begin
        errors++; $display("FAIL startup_blank: edge %0d blank_n %b want %b", i, if_a.vga_blank_n, (i >= 3));
      end
      if (int'(if_a.image_addr) !== exp_addr(0, k_a)) begin
        errors++; $display("FAIL startup_addr: edge %0d addr %0d want %0d", i, if_a.image_addr, exp_addr(0, k_a));
      end
    end
  endtask

  task automatic test_line_timing();
    logic prev_hs, prev_bl;
    int hs_start, bl_start, last_hs, n_hs, n_bl;
    prev_hs = if_a.vga_hs; prev_bl = if_a.vga_blank_n;
    hs_start = -1; bl_start = -1; last_hs = -1; n_hs = 0; n_bl = 0;
    while (k_a < 3 * 800 + 23) begin
      step();
      if (prev_hs && !if_a.vga_hs) begin
        hs_start = k_a;
        checks++;
        if ((k_a - 3) % 800 != 656) begin
          errors++; $display("FAIL hs_start: line offset %0d want 656", (k_a - 3) % 800);
        end
        if (last_hs >= 0) begin
          checks++;
          if (k_a - last_hs != 800) begin
            errors++; $display("FAIL hs_period: got %0d want 800", k_a - last_hs);
          end
        end
        last_hs = k_a;
      end
      if (!prev_hs && if_a.vga_hs && hs_start >= 0) begin
        n_hs++; checks++;
        if (k_a - hs_start != 96) begin
          errors++; $display("FAIL hs_width: got %0d want 96", k_a - hs_start);
        end
      end
      if (!prev_bl && if_a.vga_blank_n) bl_start = k_a;
      if (prev_bl && !if_a.vga_blank_n && bl_start >= 0) begin
        n_bl++; checks++;
        if (k_a - bl_start != 640) begin
          errors++; $display("FAIL blank_width: got %0d want 640", k_a - bl_start);
        end
      end
      prev_hs = if_a.vga_hs; prev_bl = if_a.vga_blank_n;
    end
    checks += 2;
    if (n_hs != 3) begin
      errors++; $display("FAIL hs_pulses: got %0d want 3", n_hs);
    end
    if (n_bl != 2) begin
      errors++; $display("FAIL blank_runs: got %0d want 2", n_bl);
    end
  endtask

  task automatic test_small_frame();
    logic prev_vs, prev_fs;
    int vs_start, last_fs, n_vs, n_fs;
    prev_vs = if_c.vga_vs; prev_fs = if_c.frame_start;
    vs_start = -1; last_fs = -1; n_vs = 0; n_fs = 0;
    repeat (3 * 456) begin
      step();
      checks += 2;
      if (pins_c !== exp_pins(2, k_c)) begin
        errors++; $display("FAIL small_pins: k %0d got %h want %h", k_c, pins_c, exp_pins(2, k_c));
      end
      if (int'(if_c.image_addr) !== exp_addr(2, k_c)) begin
        errors++; $display("FAIL small_addr: k %0d got %0d want %0d", k_c, if_c.image_addr, exp_addr(2, k_c));
      end
      if (prev_vs && !if_c.vga_vs) vs_start = k_c;
      if (!prev_vs && if_c.vga_vs && vs_start >= 0) begin
        n_vs++; checks++;
        if (k_c - vs_start != 48) begin
          errors++; $display("FAIL small_vs_width: got %0d want 48", k_c - vs_start);
        end
      end
      if (!prev_fs && if_c.frame_start) begin
        if (last_fs >= 0) begin
          n_fs++; checks++;
          if (k_c - last_fs != 456) begin
            errors++; $display("FAIL small_fs_period: got %0d want 456", k_c - last_fs);
          end
        end
        last_fs = k_c;
      end
      prev_vs = if_c.vga_vs; prev_fs = if_c.frame_start;
    end
    checks++;
    if (n_vs < 2 || n_fs < 2) begin
      errors++; $display("FAIL small_events: vs %0d fs %0d want >=2 each", n_vs, n_fs);
    end
  endtask

  task automatic check_ab();
    checks += 4;
    if (pins_a !== exp_pins(0, k_a)) begin
      errors++; $display("FAIL pins_a: k %0d got %h want %h", k_a, pins_a, exp_pins(0, k_a));
    end
    if (int'(if_a.image_addr) !== exp_addr(0, k_a) || if_a.image_addr > 13'd6399) begin
      errors++; $display("FAIL addr_a: k %0d got %0d want %0d", k_a, if_a.image_addr, exp_addr(0, k_a));
    end
    if (pins_b !== exp_pins(1, k_b)) begin
      errors++; $display("FAIL pins_b: k %0d got %h want %h", k_b, pins_b, exp_pins(1, k_b));
    end
    if (int'(if_b.image_addr) !== exp_addr(1, k_b)) begin
      errors++; $display("FAIL addr_b: k %0d got %0d want %0d", k_b, if_b.image_addr, exp_addr(1, k_b));
    end
  endtask

  task automatic test_image_window(input int stop_k);
    while (k_a < stop_k) begin
      step();
      check_ab();
      if (k_a == 3 + 79 || k_a == 3 + 80 || k_a == 800 + 3) begin
        checks++;
        if (pins_a[27:4] !== ((k_a == 3 + 80) ? 24'd0 : ((k_a == 3 + 79) ? 24'd79 : 24'd80)) || !if_a.vga_blank_n) begin
          errors++; $display("FAIL window_edge_a: k %0d rgb %0d blank %b", k_a, pins_a[27:4], if_a.vga_blank_n);
        end
      end
      if (k_b == 50 * 800 + 100 + 4) begin
        checks++;
        if (pins_b[27:4] !== rom_tab[0]) begin
          errors++; $display("FAIL first_rom_b: rgb %h want %h", pins_b[27:4], rom_tab[0]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int hold;
    hold = $urandom_range(1, 4);
    rst_b = 1'b0;
    #1;
    checks++;
    if (pins_b !== PINS_RST || if_b.image_addr !== 13'd0) begin
      errors++; $display("FAIL async_reset_b: pins %h addr %0d want %h addr 0", pins_b, if_b.image_addr, PINS_RST);
    end
    repeat (hold) begin
      step();
      checks++;
      if (pins_b !== PINS_RST || if_b.image_addr !== 13'd0) begin
        errors++; $display("FAIL hold_reset_b: pins %h addr %0d", pins_b, if_b.image_addr);
      end
    end
    rst_b = 1'b1;
    repeat (1000) begin
      step();
      check_ab();
      if (k_b == 4) begin
        checks++;
        if (if_b.frame_start !== 1'b1 || if_b.image_addr !== 13'd0) begin
          errors++; $display("FAIL restart_b: fs %b addr %0d want 1 addr 0", if_b.frame_start, if_b.image_addr);
        end
      end
    end
  endtask

  task automatic test_image_tail();
    while (k_a < 81 * 800 + 13) begin
      step();
      check_ab();
      if (k_a == 79 * 800 + 79 + 3) begin
        checks++;
        if (pins_a[27:4] !== 24'd6399) begin
          errors++; $display("FAIL last_pixel: rgb %0d want 6399", pins_a[27:4]);
        end
      end
      if (k_a >= 80 * 800 + 3 && k_a < 80 * 800 + 643) begin
        checks++;
        if (pins_a[27:4] !== 24'd0 || !if_a.vga_blank_n) begin
          errors++; $display("FAIL line80_bg: k %0d rgb %0d blank %b", k_a, pins_a[27:4], if_a.vga_blank_n);
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 8192; i++) rom_tab[i] = 24'($urandom);
    test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    test_startup();
    test_line_timing();
    test_small_frame();
    test_image_window(60 * 800 + 4 + $urandom_range(20, 700));
    test_reset_midframe();
    test_image_tail();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
